// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and line idle level.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic IDLE_LVL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous inputs; resets to all-ones (UART idle level).
module uart_rx_sync #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with an inline F/BAUD divider and registered valid/frame_err strobes.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote over mid-1/mid/mid+1, deciding one cycle later.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD = 115200,
  parameter int F    = 50000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = F / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
  localparam int START_DEC    = HALF_BIT;
`else
  localparam int START_DEC    = HALF_BIT - 1;
`endif
  localparam int BIT_DEC      = CLKS_PER_BIT - 1;

  if (CLKS_PER_BIT < 8) begin : g_div_check
    $error("uart_rx: CLKS_PER_BIT=%0d is below the minimum of 8", CLKS_PER_BIT);
  end

  rx_state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [DATA_BITS-1:0] r_data, w_data_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_ferr, w_ferr_nxt;
  logic                 w_rx_s;
  logic                 w_bit;

  uart_rx_sync #(.WIDTH(1)) u_sync (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Two previous rx_s samples; with the current one they cover mid-1..mid+1 at decision time.
  logic [1:0] r_hist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= {2{IDLE_LVL}};
    end else begin
      r_hist <= {r_hist[0], w_rx_s};
    end
  end

  assign w_bit = maj3(r_hist[1], r_hist[0], w_rx_s);
`else
  assign w_bit = w_rx_s;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_rx_s != IDLE_LVL) begin
          w_state_nxt = START;
        end
      end
      START: begin
        if (r_cnt == CNT_W'(START_DEC)) begin
          w_cnt_nxt = '0;
          if (w_bit == IDLE_LVL) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DATA;
            w_idx_nxt   = '0;
          end
        end
      end
      DATA: begin
        if (r_cnt == CNT_W'(BIT_DEC)) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_bit, r_shift[DATA_BITS-1:1]};
          if (r_idx == IDX_W'(DATA_BITS - 1)) begin
            w_state_nxt = STOP;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (r_cnt == CNT_W'(BIT_DEC)) begin
          w_cnt_nxt = '0;
          if (w_bit == IDLE_LVL) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must return high before another start bit counts.
        w_cnt_nxt = '0;
        if (w_rx_s == IDLE_LVL) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != IDLE);

endmodule
